vga_ram_arbiter: RTL

VGA_RAM_ARBITER -- requirements
Module: vga_ram_arbiter

---
 rtl/vga_ram_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/vga_ram_arbiter.sv
// vga_ram_arbiter: round-robin arbiter giving two masters one RAM port, with a
// full-RAM clear sweep that locks both masters out while it runs.
module vga_ram_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic                m0_readdatavalid,
    output logic [DATA_W-1:0]   m0_readdata,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic                m1_readdatavalid,
    output logic [DATA_W-1:0]   m1_readdata,
    input  logic                clear_req,
    output logic                clear_busy,
    output logic                clear_done,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    input  logic [DATA_W-1:0]   ram_readdata
);
    typedef enum logic {ARB, CLEAR} state_t;
    state_t state, state_nx;
    logic ptr, ptr_nx;
    logic [ADDR_W-1:0] cnt;
    logic req0, req1, g0, g1, last;
    // Requests are masked during reset so the RAM port stays idle while reset is held.
    assign req0 = (m0_read | m0_write) & ~reset;
    assign req1 = (m1_read | m1_write) & ~reset;
    assign last = cnt == ADDR_W'(DEPTH - 1);
    assign m0_waitrequest = ~g0;
    assign m1_waitrequest = ~g1;
    assign m0_readdata = ram_readdata;
    assign m1_readdata = ram_readdata;
    always_comb begin
        state_nx = state;
        ptr_nx = ptr;
        g0 = 1'b0;
        g1 = 1'b0;
        clear_done = 1'b0;
        ram_address = m0_address;
        ram_byteenable = m0_byteenable;
        ram_writedata = m0_writedata;
        ram_chipselect = 1'b0;
        ram_write = 1'b0;
        if (state == CLEAR) begin
            ram_address = cnt;
            ram_byteenable = '1;
            ram_writedata = '0;
            ram_chipselect = 1'b1;
            ram_write = 1'b1;
            clear_done = last;
            state_nx = last ? ARB : CLEAR;
        end else begin
            g0 = req0 & (~req1 | ~ptr);
            g1 = req1 & ~g0;
            ptr_nx = g0 ? 1'b1 : g1 ? 1'b0 : ptr;
            state_nx = clear_req ? CLEAR : ARB;
            ram_address = g1 ? m1_address : m0_address;
            ram_byteenable = g1 ? m1_byteenable : m0_byteenable;
            ram_writedata = g1 ? m1_writedata : m0_writedata;
            ram_chipselect = g0 | g1;
            ram_write = g0 ? m0_write : (g1 & m1_write);
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB;
            ptr <= 1'b0;
            cnt <= '0;
            clear_busy <= 1'b0;
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
        end else begin
            state <= state_nx;
            ptr <= ptr_nx;
            cnt <= (state == CLEAR && !last) ? cnt + 1'b1 : '0;
            clear_busy <= state_nx == CLEAR;
            m0_readdatavalid <= g0 & ~m0_write;
            m1_readdatavalid <= g1 & ~m1_write;
        end
    end
endmodule
